// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the accumulator ALU: opcode constants, error codes
//   and the controller state encoding. Other users of the calculator datapath
//   (testbenches, the middleware bridge) import this package.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Operation codes, captured on accept
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_CLR = 4'b1100;
  localparam logic [3:0] OP_EXP = 4'b1111;

  // Completion status, held until the next completion
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Unsigned restoring divider, one quotient bit per clock, MSB first.
//   The first bit is produced on the same edge that sees start_i, so the
//   quotient is ready (done_o high) WIDTH-1 edges later, WIDTH cycles total.
//   done_o is a one-cycle pulse.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      load dividend_i/divisor_i and begin (divisor must be nonzero)
//   dividend_i   numerator
//   divisor_i    denominator
//   done_o       quotient_o valid this cycle
//   quotient_o   result of dividend_i / divisor_i
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             active_q;

  logic [WIDTH-1:0] rem_in, quo_in, dvs_in, rem_d, quo_d;
  logic [WIDTH:0]   shifted, trial;

  // One restoring step. quo holds the not-yet-consumed dividend bits at the
  // top while quotient bits shift in at the bottom. On start the step runs
  // directly on the incoming operands.
  always_comb begin
    rem_in  = start_i ? '0 : rem_q;
    quo_in  = start_i ? dividend_i : quo_q;
    dvs_in  = start_i ? divisor_i : dvs_q;
    shifted = {rem_in, quo_in[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_in};
    if (trial[WIDTH]) begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= divisor_i;
      cnt_q    <= CW'(WIDTH - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - CW'(1);
      end else begin
        active_q <= 1'b0;
      end
    end
  end

  assign done_o     = active_q && (cnt_q == '0);
  assign quotient_o = quo_q;

endmodule

// File: rtl/param_accum_alu.sv
// ---------------------------------------------------------------------------
// param_accum_alu
//   Multi-cycle accumulator ALU. Each accepted op combines operand_p (and
//   operand_q for EXP) with the accumulator and writes the result back.
//   MUL and EXP share one WIDTHxWIDTH multiplier; DIV uses seq_divider.
//   Build option: define ALU_SATURATE_EN to make overflow write all-ones
//   (ADD/MUL/EXP) and SUB borrow write zero instead of leaving acc unchanged.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   op request handshake
//   opcode              operation (see alu_pkg)
//   operand_p           primary operand
//   operand_q           exponent for EXP
//   result              accumulator value
//   out_valid           one-cycle completion pulse
//   error_code          status of last completed op
//   busy                multi-cycle op in progress
// ---------------------------------------------------------------------------
module param_accum_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MAX_EXP = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_p,
  input  logic [WIDTH-1:0] operand_q,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [1:0]       error_code,
  output logic             busy
);

  localparam int CNT_W = (MAX_EXP < 1) ? 1 : $clog2(MAX_EXP + 1);

`ifdef ALU_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, p_q, p_d, tmp_q, tmp_d;
  logic [3:0]       op_q, op_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               accept;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   mul_a;
  logic [2*WIDTH-1:0] prod;
  logic               prod_ovf;
  logic               div_start, div_done;
  logic [WIDTH-1:0]   div_quot;

  assign accept   = in_valid && in_ready;
  assign sum      = {1'b0, acc_q} + {1'b0, operand_p};
  assign diff     = {1'b0, acc_q} - {1'b0, operand_p};
  // EXP multiplies its running power, MUL multiplies the accumulator
  assign mul_a    = (op_q == OP_EXP) ? tmp_q : acc_q;
  assign prod     = (2*WIDTH)'(mul_a) * (2*WIDTH)'(p_q);
  assign prod_ovf = |prod[2*WIDTH-1:WIDTH];

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (acc_q),
    .divisor_i  (operand_p),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    err_d     = err_q;
    op_d      = op_q;
    p_d       = p_q;
    tmp_d     = tmp_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          op_d    = opcode;
          p_d     = operand_p;
          state_d = ST_DONE;
          // err_d is only touched by single-cycle ops here; multi-cycle ops
          // keep the previous status visible until they complete
          case (opcode)
            OP_NOP: err_d = ERR_OK;
            OP_ADD: begin
              if (sum[WIDTH]) begin
                err_d = ERR_OVF;
                acc_d = SAT ? '1 : acc_q;
              end else begin
                err_d = ERR_OK;
                acc_d = sum[WIDTH-1:0];
              end
            end
            OP_SUB: begin
              if (diff[WIDTH]) begin
                err_d = ERR_OVF;
                acc_d = SAT ? '0 : acc_q;
              end else begin
                err_d = ERR_OK;
                acc_d = diff[WIDTH-1:0];
              end
            end
            OP_CLR: begin
              err_d = ERR_OK;
              acc_d = '0;
            end
            OP_MUL: state_d = ST_BUSY;
            OP_DIV: begin
              if (operand_p == '0) begin
                err_d = ERR_DIV0;
              end else begin
                div_start = 1'b1;
                state_d   = ST_BUSY;
              end
            end
            OP_EXP: begin
              // An out-of-range exponent is rejected without touching acc,
              // even in the saturating build
              if (operand_q > WIDTH'(MAX_EXP)) begin
                err_d = ERR_OVF;
              end else if (operand_q == '0) begin
                err_d = ERR_OK;
                acc_d = WIDTH'(1);
              end else begin
                tmp_d   = WIDTH'(1);
                cnt_d   = operand_q[CNT_W-1:0];
                state_d = ST_BUSY;
              end
            end
            default: err_d = ERR_ILL;
          endcase
        end
      end
      ST_BUSY: begin
        case (op_q)
          OP_MUL: begin
            state_d = ST_DONE;
            if (prod_ovf) begin
              err_d = ERR_OVF;
              acc_d = SAT ? '1 : acc_q;
            end else begin
              err_d = ERR_OK;
              acc_d = prod[WIDTH-1:0];
            end
          end
          OP_DIV: begin
            if (div_done) begin
              state_d = ST_DONE;
              err_d   = ERR_OK;
              acc_d   = div_quot;
            end
          end
          OP_EXP: begin
            // cnt_q counts the multiply steps still to do, this one included
            if (prod_ovf) begin
              state_d = ST_DONE;
              err_d   = ERR_OVF;
              acc_d   = SAT ? '1 : acc_q;
            end else if (cnt_q == CNT_W'(1)) begin
              state_d = ST_DONE;
              err_d   = ERR_OK;
              acc_d   = prod[WIDTH-1:0];
            end else begin
              tmp_d = prod[WIDTH-1:0];
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          default: state_d = ST_DONE;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      err_q   <= ERR_OK;
      op_q    <= OP_NOP;
      p_q     <= '0;
      tmp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      op_q    <= op_d;
      p_q     <= p_d;
      tmp_q   <= tmp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q == ST_BUSY);
  assign result     = acc_q;
  assign error_code = err_q;

endmodule
